redundant_result_checker: RTL
=============================

// Module: redundant_result_checker
// PURPOSE
//  Multi-cycle comparator for the Curve448 fault-detection path. Compares a primary
//  WIDTH-bit result against its redundant recomputation, CHUNK bits per cycle.
//  Reports a per-operation error flag, the index of the first mismatching chunk,
//  and a saturating error counter. Sits after the ladder/field-op duplicate datapaths.
// PARAMETERS
//  WIDTH  448  compared operand width; all WIDTH bits are compared, none excluded
//  CHUNK  64   bits compared per cycle; N = ceil(WIDTH/CHUNK) chunks, IDX_W = max(1,$clog2(N))
//  CNT_W  8    width of the saturating error counter
// PORTS
//  clk            in   1      rising-edge clock
//  rst            in   1      synchronous, active-high reset
//  start          in   1      request a comparison; operands sampled when accepted
//  operand1       in   WIDTH  primary result
//  operand2       in   WIDTH  redundant result
//  clear_count    in   1      synchronous clear of err_count
//  busy           out  1      comparison in progress
//  done           out  1      one-cycle pulse: result outputs valid/updated
//  error          out  1      1 = last completed comparison found a mismatch
//  mismatch_chunk out  IDX_W  first mismatching chunk index (0 if error=0)
//  err_count      out  CNT_W  number of erroneous comparisons since reset/clear
// BEHAVIOUR
//  Reset: state IDLE; busy=0, done=0, error=0, mismatch_chunk=0, err_count=0,
//   captured operands and chunk index cleared. Reset mid-scan aborts; no done pulse.
//  FSM IDLE -> SCAN -> DONE -> IDLE (or DONE -> SCAN on a new start).
//  Accept: start=1 while state is IDLE or DONE. In acceptance cycle t: operand1/2
//   captured into internal registers, idx<=0, running flag/first-index cleared, state<=SCAN.
//   start in SCAN is ignored (no queueing); operand changes after t have no effect.
//  SCAN: cycles t+1..t+N, busy=1. Chunk idx = bits [idx*CHUNK +: CHUNK]; last chunk
//   zero-padded above WIDTH-1 in both operands. If chunk differs and running flag=0,
//   record idx as first index; set running flag. idx increments; after idx=N-1 -> DONE.
//  DONE: cycle t+N+1: done=1, busy=0; error<=running flag, mismatch_chunk<=first index
//   (0 if no mismatch). Total latency start-accept -> done = N+1 cycles.
//  error/mismatch_chunk hold from done until the next done; they are not cleared at
//   start. Back-to-back: start during DONE accepted; done of next op at +N+1 again.
//  err_count: +1 in the done cycle when error result is 1; saturates at 2^CNT_W-1.
//   clear_count=1 forces 0 next cycle and wins over a simultaneous increment.
//  Only outputs change on clk edges; no combinational path from inputs to outputs.
// TESTING (WIDTH=448, CHUNK=64 -> N=7 unless noted)
//  1 equal random operands, start at t -> busy t+1..t+7, done at t+8, error=0, mismatch_chunk=0.
//  2 operand2 = operand1 ^ (1<<447) -> error=1, mismatch_chunk=6, err_count=1.
//  3 bits 70 and 300 flipped -> mismatch_chunk=1; bit 0 only flipped -> mismatch_chunk=0, error=1.
//  4 CHUNK=100 (N=5, last chunk 48 bits): bit 447 flipped -> mismatch_chunk=4, done at t+6.
//  5 start pulsed at t+3 during SCAN with other operands -> ignored, result reflects t operands;
//    start held through DONE -> second op accepted, second done 8 cycles after first.
//  6 CNT_W=2, four erroneous ops -> err_count=3; clear_count coincident with 5th done -> 0;
//    rst asserted at t+4 -> no done, all outputs 0 next cycle.

Source files
------------

// File: rtl/redundant_result_checker.sv
// redundant_result_checker
// Compares a primary result with its redundant recomputation one CHUNK-bit
// slice per cycle. It reports whether the two differ, the index of the first
// slice that differs, and a saturating count of the comparisons that found
// a difference.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start
// SCAN  | comparing one chunk per cycle, idx = 0 .. N-1
// DONE  | done pulse; results updated; a new start is accepted here too
module redundant_result_checker #(
    parameter  int WIDTH = 448,
    parameter  int CHUNK = 64,
    parameter  int CNT_W = 8,
    localparam int N     = (WIDTH + CHUNK - 1) / CHUNK,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic             clear_count,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [IDX_W-1:0] mismatch_chunk,
    output logic [CNT_W-1:0] err_count
);

    // Operands are held padded to a whole number of chunks. The padding bits
    // are zero in both operands, so they never produce a mismatch.
    localparam int PW = N * CHUNK;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [PW-1:0]    op1_q;
    logic [PW-1:0]    op2_q;
    logic [IDX_W-1:0] idx;
    logic             run_flag;
    logic [IDX_W-1:0] first_idx;

    logic             chunk_diff;
    logic             last_chunk;

    // The operand registers shift right each SCAN cycle, so the chunk being
    // compared is always in the low CHUNK bits. This avoids a wide mux.
    assign chunk_diff = (op1_q[CHUNK-1:0] != op2_q[CHUNK-1:0]);
    assign last_chunk = (idx == LAST_IDX);

    // Sequencer: accepts a request, walks the chunks, and publishes the result
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            op1_q          <= '0;
            op2_q          <= '0;
            idx            <= '0;
            run_flag       <= 1'b0;
            first_idx      <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            mismatch_chunk <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        op1_q     <= PW'(operand1);
                        op2_q     <= PW'(operand2);
                        idx       <= '0;
                        run_flag  <= 1'b0;
                        first_idx <= '0;
                        busy      <= 1'b1;
                        state     <= ST_SCAN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                ST_SCAN: begin
                    op1_q <= op1_q >> CHUNK;
                    op2_q <= op2_q >> CHUNK;
                    if (chunk_diff && !run_flag) begin
                        first_idx <= idx;
                    end
                    if (chunk_diff) begin
                        run_flag <= 1'b1;
                    end
                    if (last_chunk) begin
                        // The last chunk is folded in directly, because its
                        // contribution to run_flag/first_idx is not yet registered.
                        busy           <= 1'b0;
                        done           <= 1'b1;
                        error          <= run_flag | chunk_diff;
                        mismatch_chunk <= (!run_flag && chunk_diff) ? idx : first_idx;
                        state          <= ST_DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Error counter: counts during the done cycle of a failing comparison.
    // It stops at its maximum value. A clear takes priority over a count.
    always_ff @(posedge clk) begin
        if (rst || clear_count) begin
            err_count <= '0;
        end else if (done && error && (err_count != CNT_MAX)) begin
            err_count <= err_count + CNT_W'(1);
        end
    end

endmodule
